// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion sequencer.
//   sar_state_e    : sequencer states (IDLE, SAMPLE, CONVERT)
//   NBITS_DEF      : default converter resolution
//   sample_cnt_w() : width of the track/hold cycle counter
//   bit_idx_w()    : width of the bit-trial index
//   midscale()     : first trial code, only the MSB set
package sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2
  } sar_state_e;

  localparam int NBITS_DEF         = 8;
  localparam int SAMPLE_CYCLES_DEF = 2;

  // The counter must be able to hold SAMPLE_CYCLES-1.
  function automatic int sample_cnt_w(input int sample_cycles);
    return (sample_cycles > 1) ? $clog2(sample_cycles + 1) : 1;
  endfunction

  function automatic int bit_idx_w(input int nbits);
    return (nbits > 1) ? $clog2(nbits) : 1;
  endfunction

  function automatic logic [31:0] midscale(input int nbits);
    return 32'd1 << (nbits - 1);
  endfunction

endpackage

// File: rtl/sar_result_buf.sv
// One-entry output register for finished conversion codes.
//   clk, rst_ni       : clock, asynchronous active-low reset
//   load_i, data_i    : a new code from the sequencer, written on this edge
//   ready_i           : consumer accepts the held code
//   clr_i             : clears the sticky overrun flag
//   data_o, valid_o   : held code and its valid flag
//   overrun_o         : sticky, a held code was overwritten before it was read
//
// Handshake: the code in data_o is transferred on any rising edge where
// valid_o && ready_i; valid_o never drops without that transfer, and a
// load on the same edge replaces the transferred code and keeps valid_o high.
module sar_result_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  input  logic         clr_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         overrun_o
);

  logic [W-1:0] data_q;
  logic         valid_q;
  logic         overrun_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load_i) begin
        data_q  <= data_i;
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
      // A held code that is not being taken this edge gets lost; the set
      // takes priority over a simultaneous clear so no loss goes unreported.
      if (load_i && valid_q && !ready_i) begin
        overrun_q <= 1'b1;
      end else if (clr_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/sar_conv_ctrl.sv
// Conversion sequencer for a successive-approximation ADC.
//   clk, reset     : conversion clock, asynchronous active-low reset
//   start          : conversion request, only honoured in IDLE
//   cmp_in         : comparator, 1 = Vin >= DAC(trial code), keep the bit
//   sample         : track/hold switch, 1 = track
//   dac_code       : trial code for the DAC
//   busy           : high while sampling or converting
//   result         : last completed code
//   result_valid   : result holds an unread code
//   result_ready   : consumer takes result when result_valid is high
//   overrun        : sticky, a code was overwritten before it was read
//   overrun_clr    : synchronous clear of overrun
//   state_dbg      : current sequencer state
module sar_conv_ctrl
  import sar_pkg::*;
#(
  parameter int NBITS         = NBITS_DEF,
  parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cmp_in,
  output logic             sample,
  output logic [NBITS-1:0] dac_code,
  output logic             busy,
  output logic [NBITS-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output sar_state_e       state_dbg
);

  localparam int               SCW       = sample_cnt_w(SAMPLE_CYCLES);
  localparam int               IW        = bit_idx_w(NBITS);
  localparam logic [NBITS-1:0] MID       = NBITS'(midscale(NBITS));
  localparam logic [SCW-1:0]   SAMP_LAST = SCW'(SAMPLE_CYCLES - 1);
  localparam logic [IW-1:0]    IDX_MSB   = IW'(NBITS - 1);

  sar_state_e       state_q;
  logic [SCW-1:0]   samp_cnt_q;
  logic [IW-1:0]    bit_idx_q;
  logic [NBITS-1:0] trial_q;
  logic             sample_q;
  logic             busy_q;

  logic [NBITS-1:0] trial_d;
  logic [IW-1:0]    idx_m1;
  logic             code_done;

  assign idx_m1    = bit_idx_q - 1'b1;
  assign code_done = (state_q == ST_CONVERT) && (bit_idx_q == '0);

  // Next trial: latch the decision into the bit under test and raise the
  // next lower bit. When the LSB is under test this is the finished code.
  always_comb begin
    trial_d            = trial_q;
    trial_d[bit_idx_q] = cmp_in;
    if (bit_idx_q != '0) begin
      trial_d[idx_m1] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      samp_cnt_q <= '0;
      bit_idx_q  <= IDX_MSB;
      trial_q    <= MID;
      sample_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_SAMPLE;
            samp_cnt_q <= '0;
            sample_q   <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (samp_cnt_q == SAMP_LAST) begin
            state_q   <= ST_CONVERT;
            sample_q  <= 1'b0;
            bit_idx_q <= IDX_MSB;
            trial_q   <= MID;
          end else begin
            samp_cnt_q <= samp_cnt_q + 1'b1;
          end
        end
        ST_CONVERT: begin
          if (bit_idx_q == '0) begin
            // Finished code leaves through the result buffer on this edge.
            trial_q   <= MID;
            bit_idx_q <= IDX_MSB;
            if (start) begin
              state_q    <= ST_SAMPLE;
              samp_cnt_q <= '0;
              sample_q   <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            trial_q   <= trial_d;
            bit_idx_q <= idx_m1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          samp_cnt_q <= '0;
          bit_idx_q  <= IDX_MSB;
          trial_q    <= MID;
          sample_q   <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  sar_result_buf #(
    .W(NBITS)
  ) u_result_buf (
    .clk      (clk),
    .rst_ni   (reset),
    .load_i   (code_done),
    .data_i   (trial_d),
    .ready_i  (result_ready),
    .clr_i    (overrun_clr),
    .data_o   (result),
    .valid_o  (result_valid),
    .overrun_o(overrun)
  );

  assign sample    = sample_q;
  assign dac_code  = trial_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sar_conv_ctrl.sv
module tb_sar_conv_ctrl;
  import sar_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       result_ready = 1'b0;
  logic       overrun_clr = 1'b0;
  logic       cmp_in;
  logic       sample;
  logic       busy;
  logic       result_valid;
  logic       overrun;
  logic [7:0] dac_code;
  logic [7:0] result;
  sar_state_e state_dbg;

  always #5 clk = ~clk;

  // Analog front-end model: the held input compared against the DAC.
  logic [7:0] vin = 8'h00;
  assign cmp_in = (vin >= dac_code);

  sar_conv_ctrl #(
    .NBITS(8),
    .SAMPLE_CYCLES(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cmp_in      (cmp_in),
    .sample      (sample),
    .dac_code    (dac_code),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] trials[$];
  logic [7:0] a5_tab[8];
  int         samp_n;
  int         lat;
  bit         valid_mid;
  int         n;
  int         nres;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion from a single start pulse; records trial codes, sample
  // cycles and the cycle count until busy falls.
  task automatic convert(input logic [7:0] v);
    vin = v;
    trials.delete();
    samp_n = 0;
    lat = 0;
    valid_mid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (busy && lat < 40) begin
      if (sample) samp_n++;
      else trials.push_back(dac_code);
      if (result_valid) valid_mid = 1'b1;
      tick();
      lat++;
    end
    chk("conv_latency", lat, 10);
    chk("conv_sample_cycles", samp_n, 2);
  endtask

  task automatic consume();
    result_ready = 1'b1;
    tick();
    chk("consume_valid_drop", result_valid, 0);
    result_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    a5_tab = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    // Reset state
    #12;
    chk("rst_sample", sample, 0);
    chk("rst_dac", dac_code, 8'h80);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_state", state_dbg, ST_IDLE);
    reset = 1'b1;
    tick();

    // Vin 0xA5: full trial sequence
    convert(8'hA5);
    chk("a5_ntrials", trials.size(), 8);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] t;
      t = (k < trials.size()) ? trials[k] : 8'h00;
      chk("a5_trial", t, a5_tab[k]);
    end
    chk("a5_valid_early", valid_mid, 0);
    chk("a5_result", result, 8'hA5);
    chk("a5_valid", result_valid, 1);
    chk("a5_dac_mid", dac_code, 8'h80);
    chk("a5_overrun", overrun, 0);
    consume();

    // Extremes
    convert(8'h00);
    chk("zero_last_trial", trials[$], 8'h01);
    chk("zero_result", result, 8'h00);
    consume();
    convert(8'hFF);
    chk("ff_last_trial", trials[$], 8'hFF);
    chk("ff_result", result, 8'hFF);
    consume();

    // Back-to-back with start held
    result_ready = 1'b1;
    vin = 8'h3C;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    start = 1'b1;
    tick();
    n = 0;
    while (!result_valid && n < 40) begin
      tick();
      n++;
    end
    chk("b2b_lat1", n, 10);
    chk("b2b_res1", result, exp_q.pop_front());
    chk("b2b_no_gap_busy", busy, 1);
    chk("b2b_no_gap_sample", sample, 1);
    start = 1'b0;
    vin = 8'hC3;
    n = 0;
    do begin
      tick();
      n++;
    end while (!result_valid && n < 40);
    chk("b2b_lat2", n, 10);
    chk("b2b_res2", result, exp_q.pop_front());
    chk("b2b_overrun", overrun, 0);
    tick();
    chk("b2b_valid_drop", result_valid, 0);
    chk("b2b_idle", busy, 0);
    result_ready = 1'b0;

    // Overrun, then clear, then consume
    convert(8'h5A);
    convert(8'h33);
    chk("ovr_result", result, 8'h33);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid", result_valid, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    chk("ovr_valid_kept", result_valid, 1);
    consume();

    // Overrun set coinciding with clear: set wins
    convert(8'h11);
    overrun_clr = 1'b1;
    convert(8'h22);
    overrun_clr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    chk("ovr_set_result", result, 8'h22);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    consume();

    // Asynchronous reset with bit 4 under test
    vin = 8'h5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("abort_dac_i4", dac_code, 8'h50);
    #2 reset = 1'b0;
    #1;
    chk("abort_sample", sample, 0);
    chk("abort_dac", dac_code, 8'h80);
    chk("abort_busy", busy, 0);
    chk("abort_valid", result_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_overrun", overrun, 0);
    chk("abort_state", state_dbg, ST_IDLE);
    tick();
    tick();
    chk("abort_hold_valid", result_valid, 0);
    reset = 1'b1;
    tick();
    convert(8'h77);
    chk("post_rst_result", result, 8'h77);
    chk("post_rst_valid", result_valid, 1);
    consume();

    // Start pulses during SAMPLE and CONVERT are ignored
    result_ready = 1'b1;
    vin = 8'hE1;
    nres = 0;
    for (int i = 0; i < 30; i++) begin
      start = (i == 0 || i == 1 || i == 6);
      tick();
      if (result_valid) nres++;
    end
    start = 1'b0;
    chk("ignore_nres", nres, 1);
    chk("ignore_result", result, 8'hE1);
    chk("ignore_idle", busy, 0);
    result_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
